// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin write-port arbiter with init sweep for the register file
module regfile_wr_arbiter #(
    parameter int              NREQ     = 4,
    parameter int              AW       = 3,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_start,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy_init
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {S_INIT, S_ARB} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [IW-1:0]   idx, gidx;
    logic            found, init, xfer;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        idx   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ptr_q + IW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign init      = (state_q == S_INIT);
    assign xfer      = !init && found;
    assign busy_init = init;
    assign req_ready = xfer ? (NREQ'(1) << gidx) : '0;
    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign grant_id  = gid_q;

    // Next state: sweep writes during INIT, granted requester's write during ARB
    always_comb begin
        state_d = init ? ((cnt_q == '1) ? S_ARB : S_INIT) : (init_start ? S_INIT : S_ARB);
        cnt_d   = init ? cnt_q + 1'b1 : '0;
        we_d    = init || xfer;
        waddr_d = init ? cnt_q : xfer ? req_addr[gidx*AW +: AW] : waddr_q;
        wdata_d = init ? INIT_VAL : xfer ? req_data[gidx*DW +: DW] : wdata_q;
        gid_d   = init ? '0 : xfer ? gidx : gid_q;
        ptr_d   = xfer ? gidx : ptr_q;
    end

    // State and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed scoreboard bench for the register file write arbiter
module tb_regfile_wr_arbiter;
    localparam logic [7:0] IV = 8'h3C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [1:0]  grant_id;
    logic        busy_init;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic [1:0] g;
    } wr_t;

    wr_t q[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    regfile_wr_arbiter #(.NREQ(4), .AW(3), .DW(8), .INIT_VAL(IV)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .grant_id(grant_id), .busy_init(busy_init)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d, input logic [1:0] g);
        wr_t e;
        e.a = a;
        e.d = d;
        e.g = g;
        q.push_back(e);
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) push(3'(i), IV, 2'd0);
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    // Every write seen at the register file must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (q.size() == 0) begin
                chk("unexpected_we", {29'd0, rf_waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("waddr", 32'(rf_waddr), 32'(e.a));
                chk("wdata", 32'(rf_wdata), 32'(e.d));
                chk("grant_id", 32'(grant_id), 32'(e.g));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", 32'(rf_wdata), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy_init), 1);
        push_sweep(8);
        #18;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sweep_we", 32'(rf_we), 1);
            chk("sweep_busy", 32'(busy_init), (i < 7) ? 1 : 0);
            chk("sweep_ready", 32'(req_ready), 0);
        end

        set_req(2, 3'd5, 8'hA5);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        push(3'd5, 8'hA5, 2'd2);
        tick();
        req_valid = '0;
        chk("single_we", 32'(rf_we), 1);
        tick();
        chk("single_idle_we", 32'(rf_we), 0);

        set_req(1, 3'd1, 8'h11);
        set_req(3, 3'd3, 8'h33);
        req_valid = 4'b1010;
        #1;
        chk("rr_first", 32'(req_ready), 32'h8);
        push(3'd3, 8'h33, 2'd3);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("rr_second", 32'(req_ready), 32'h2);
        push(3'd1, 8'h11, 2'd1);
        tick();
        req_valid = '0;

        req_valid = 4'b1000;
        #1;
        chk("ptr3_ready", 32'(req_ready), 32'h8);
        push(3'd3, 8'h33, 2'd3);
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 3'(4 + i), 8'hC0 + 8'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("all_ready", 32'(req_ready), 32'(1 << (k % 4)));
            push(3'(4 + k % 4), 8'hC0 + 8'(k % 4), 2'(k % 4));
            tick();
            chk("all_we", 32'(rf_we), 1);
        end
        req_valid = '0;

        set_req(0, 3'd2, 8'h5A);
        req_valid = 4'b0001;
        init_start = 1'b1;
        #1;
        chk("init_pulse_ready", 32'(req_ready), 32'h1);
        push(3'd2, 8'h5A, 2'd0);
        push_sweep(8);
        tick();
        init_start = 1'b0;
        chk("init_busy0", 32'(busy_init), 1);
        chk("init_ready0", 32'(req_ready), 0);
        for (int i = 0; i < 8; i++) begin
            init_start = 1'b0;
            tick();
            if (i == 3) init_start = 1'b1;
            #1;
            chk("init_busy", 32'(busy_init), (i < 7) ? 1 : 0);
            chk("init_ready", 32'(req_ready), (i < 7) ? 0 : 1);
        end
        init_start = 1'b0;
        push(3'd2, 8'h5A, 2'd0);
        tick();
        req_valid = '0;
        tick();
        chk("queue_drained1", 32'(q.size()), 0);

        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        push_sweep(3);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_we", 32'(rf_we), 1);
        chk("pre_rst_waddr", 32'(rf_waddr), 3);
        chk("pre_rst_wdata", 32'(rf_wdata), 32'(IV));
        chk("pre_rst_queue", 32'(q.size()), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_we), 0);
        chk("mid_rst_waddr", 32'(rf_waddr), 0);
        chk("mid_rst_wdata", 32'(rf_wdata), 0);
        chk("mid_rst_busy", 32'(busy_init), 1);
        req_valid = 4'b0001;
        set_req(0, 3'd6, 8'h66);
        #1;
        chk("mid_rst_ready", 32'(req_ready), 0);
        push_sweep(8);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("resweep_busy", 32'(busy_init), (i < 7) ? 1 : 0);
            chk("resweep_ready", 32'(req_ready), (i < 7) ? 0 : 1);
        end
        push(3'd6, 8'h66, 2'd0);
        tick();
        req_valid = '0;
        tick();
        chk("queue_drained2", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
